// File: rtl/wb_ahb_bridge.sv
// Wishbone-classic slave to AHB-Lite master bridge: one outstanding single
// transfer at a time. The WB and AHB sides share wb_clk_i.
module wb_ahb_bridge #(
    parameter logic [7:0]  BASE_HI  = 8'h30,
    parameter logic [7:0]  AHB_HI   = 8'h00,
    parameter logic [7:0]  TIMEOUT  = 8'd255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        err_flag_o,
    input  logic        err_clr_i
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ACK} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        abort_q, abort_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [2:0]  hsize_q, hsize_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        err_q, err_d;

    logic        hit;
    logic        timeout_hit;
    logic        cyc_ok;
    logic [2:0]  dec_size;
    logic [1:0]  dec_lsb;

    assign hit         = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_HI);
    assign timeout_hit = (cnt_q + 8'd1) == TIMEOUT;
    // An ack is only owed to a master that kept its cycle open throughout.
    assign cyc_ok      = wbs_cyc_i & ~abort_q;

    always_comb begin
        dec_size = 3'b010;
        dec_lsb  = 2'b00;
        case (wbs_sel_i)
            4'b0011: dec_size = 3'b001;
            4'b1100: begin dec_size = 3'b001; dec_lsb = 2'b10; end
            4'b0001: begin dec_size = 3'b000; dec_lsb = 2'b00; end
            4'b0010: begin dec_size = 3'b000; dec_lsb = 2'b01; end
            4'b0100: begin dec_size = 3'b000; dec_lsb = 2'b10; end
            4'b1000: begin dec_size = 3'b000; dec_lsb = 2'b11; end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = 8'd0;
        abort_d  = abort_q;
        wdata_d  = wdata_q;
        ack_d    = 1'b0;
        rdata_d  = rdata_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hsize_d  = hsize_q;
        hwrite_d = hwrite_q;
        hwdata_d = hwdata_q;
        err_d    = err_clr_i ? 1'b0 : err_q;

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (hit) begin
                    state_d  = S_ADDR;
                    wdata_d  = wbs_dat_i;
                    haddr_d  = {AHB_HI, wbs_adr_i[23:2], dec_lsb};
                    hsize_d  = dec_size;
                    hwrite_d = wbs_we_i;
                    htrans_d = 2'b10;
                end
            end
            S_ADDR, S_DATA: begin
                if (!wbs_cyc_i) abort_d = 1'b1;
                if (HREADY) begin
                    if (state_q == S_ADDR) begin
                        state_d  = S_DATA;
                        htrans_d = 2'b00;
                        hwdata_d = wdata_q;
                    end else begin
                        state_d = S_ACK;
                        ack_d   = cyc_ok;
                        if (!hwrite_q) rdata_d = HRDATA;
                        if (HRESP) begin
                            err_d = 1'b1;
                            if (!hwrite_q) rdata_d = ERR_DATA;
                        end
                    end
                end else if (timeout_hit) begin
                    state_d  = S_ACK;
                    ack_d    = cyc_ok;
                    htrans_d = 2'b00;
                    err_d    = 1'b1;
                    if (!hwrite_q) rdata_d = ERR_DATA;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            abort_q  <= 1'b0;
            wdata_q  <= 32'd0;
            ack_q    <= 1'b0;
            rdata_q  <= 32'd0;
            haddr_q  <= 32'd0;
            htrans_q <= 2'b00;
            hsize_q  <= 3'b010;
            hwrite_q <= 1'b0;
            hwdata_q <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            abort_q  <= abort_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hsize_q  <= hsize_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
            err_q    <= err_d;
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = rdata_q;
    assign HADDR      = haddr_q;
    assign HTRANS     = htrans_q;
    assign HSIZE      = hsize_q;
    assign HWRITE     = hwrite_q;
    assign HWDATA     = hwdata_q;
    assign err_flag_o = err_q;

endmodule

// File: tb/tb_wb_ahb_bridge.sv
// Directed bench for wb_ahb_bridge; the bench plays both the WB master and the AHB slave.
module tb_wb_ahb_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, wdat = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hrdata = 32'h0;
    logic        hready = 1'b1, hresp = 1'b0;
    logic        err_flag;
    logic        err_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    wb_ahb_bridge dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .HADDR     (haddr),
        .HTRANS    (htrans),
        .HSIZE     (hsize),
        .HWRITE    (hwrite),
        .HWDATA    (hwdata),
        .HRDATA    (hrdata),
        .HREADY    (hready),
        .HRESP     (hresp),
        .err_flag_o(err_flag),
        .err_clr_i (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    endtask

    task automatic drop();
        cyc = 1'b0; stb = 1'b0;
    endtask

    initial begin
        // reset state
        tick(); tick();
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", rdat, 32'd0);
        chk("rst_htrans", {30'd0, htrans}, 32'd0);
        chk("rst_haddr", haddr, 32'd0);
        chk("rst_hsize", {29'd0, hsize}, 32'd2);
        chk("rst_err", {31'd0, err_flag}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: word write, zero-wait slave
        req(1'b1, 32'h3000_0010, 4'b1111, 32'hA5A5_1234);
        tick();
        chk("t1_htrans_ns", {30'd0, htrans}, 32'd2);
        chk("t1_haddr", haddr, 32'h0000_0010);
        chk("t1_hsize", {29'd0, hsize}, 32'd2);
        chk("t1_hwrite", {31'd0, hwrite}, 32'd1);
        chk("t1_ack_n1", {31'd0, ack}, 32'd0);
        tick();
        chk("t1_htrans_idle", {30'd0, htrans}, 32'd0);
        chk("t1_hwdata", hwdata, 32'hA5A5_1234);
        chk("t1_ack_n2", {31'd0, ack}, 32'd0);
        tick();
        chk("t1_ack", {31'd0, ack}, 32'd1);
        drop();
        tick();
        chk("t1_ack_pulse", {31'd0, ack}, 32'd0);

        // 2: byte read, two wait states in the data phase
        req(1'b0, 32'h3000_0020, 4'b0100, 32'h0);
        tick();
        chk("t2_haddr", haddr, 32'h0000_0022);
        chk("t2_hsize", {29'd0, hsize}, 32'd0);
        chk("t2_hwrite", {31'd0, hwrite}, 32'd0);
        tick();
        hready = 1'b0;
        tick();
        chk("t2_wait1_ack", {31'd0, ack}, 32'd0);
        tick();
        chk("t2_wait2_ack", {31'd0, ack}, 32'd0);
        hready = 1'b1; hrdata = 32'h1122_3344;
        tick();
        chk("t2_ack", {31'd0, ack}, 32'd1);
        chk("t2_dat", rdat, 32'h1122_3344);
        drop(); hrdata = 32'h0;
        tick();
        chk("t2_ack_pulse", {31'd0, ack}, 32'd0);
        chk("t2_dat_hold", rdat, 32'h1122_3344);

        // 3: address outside the window is ignored
        req(1'b0, 32'h2000_0000, 4'b1111, 32'h0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t3_htrans", {30'd0, htrans}, 32'd0);
            chk("t3_ack", {31'd0, ack}, 32'd0);
        end
        drop();
        tick();

        // 4: error response on a read, then clear
        req(1'b0, 32'h3000_0040, 4'b1111, 32'h0);
        tick();
        hresp = 1'b1; hrdata = 32'h0102_0304;
        tick();
        tick();
        chk("t4_ack", {31'd0, ack}, 32'd1);
        chk("t4_dat", rdat, 32'hDEAD_BEEF);
        chk("t4_err", {31'd0, err_flag}, 32'd1);
        drop(); hresp = 1'b0;
        tick();
        chk("t4_err_sticky", {31'd0, err_flag}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_err_clr", {31'd0, err_flag}, 32'd0);

        // back-to-back half-word reads, stb kept high across the ack
        req(1'b0, 32'h3000_0004, 4'b0011, 32'h0);
        hrdata = 32'h600D_600D;
        tick();
        chk("bb1_haddr", haddr, 32'h0000_0004);
        chk("bb1_hsize", {29'd0, hsize}, 32'd1);
        tick();
        tick();
        chk("bb1_ack", {31'd0, ack}, 32'd1);
        chk("bb1_dat", rdat, 32'h600D_600D);
        adr = 32'h3000_0008; sel = 4'b1100; hrdata = 32'h1234_5678;
        tick();
        chk("bb_no_reack", {31'd0, ack}, 32'd0);
        chk("bb_gap_htrans", {30'd0, htrans}, 32'd0);
        tick();
        chk("bb2_htrans", {30'd0, htrans}, 32'd2);
        chk("bb2_haddr", haddr, 32'h0000_000A);
        chk("bb2_hsize", {29'd0, hsize}, 32'd1);
        tick();
        tick();
        chk("bb2_ack", {31'd0, ack}, 32'd1);
        chk("bb2_dat", rdat, 32'h1234_5678);
        drop();
        tick();

        // 5: HREADY stuck low in the data phase -> timeout after 255 cycles
        req(1'b0, 32'h3000_0100, 4'b1111, 32'h0);
        hrdata = 32'h7777_7777;
        tick();
        tick();
        hready = 1'b0;
        for (int i = 0; i < 254; i++) tick();
        chk("t5_ack_early", {31'd0, ack}, 32'd0);
        tick();
        chk("t5_ack", {31'd0, ack}, 32'd1);
        chk("t5_err", {31'd0, err_flag}, 32'd1);
        chk("t5_dat", rdat, 32'hDEAD_BEEF);
        chk("t5_htrans", {30'd0, htrans}, 32'd0);
        drop();
        for (int i = 0; i < 45; i++) tick();
        hready = 1'b1;
        chk("t5_ack_after", {31'd0, ack}, 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        req(1'b1, 32'h3000_0200, 4'b0001, 32'h0000_00AB);
        tick();
        chk("t5_next_haddr", haddr, 32'h0000_0200);
        chk("t5_next_hsize", {29'd0, hsize}, 32'd0);
        tick();
        tick();
        chk("t5_next_ack", {31'd0, ack}, 32'd1);
        drop();
        tick();

        // 6: cycle dropped during an address-phase wait
        hready = 1'b0;
        req(1'b1, 32'h3000_0300, 4'b1000, 32'h5A5A_0001);
        tick();
        chk("t6_haddr", haddr, 32'h0000_0303);
        drop();
        tick();
        chk("t6_hold_htrans", {30'd0, htrans}, 32'd2);
        hready = 1'b1;
        tick();
        chk("t6_hwdata", hwdata, 32'h5A5A_0001);
        chk("t6_htrans_idle", {30'd0, htrans}, 32'd0);
        tick();
        chk("t6_no_ack", {31'd0, ack}, 32'd0);
        tick();
        chk("t6_no_ack2", {31'd0, ack}, 32'd0);

        // reset asserted in the middle of a data phase
        req(1'b1, 32'h3000_0400, 4'b0001, 32'hCAFE_F00D);
        tick();
        tick();
        hready = 1'b0;
        tick();
        chk("t6_pre_hwdata", hwdata, 32'hCAFE_F00D);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_ack", {31'd0, ack}, 32'd0);
        chk("t6_rst_dat", rdat, 32'd0);
        chk("t6_rst_htrans", {30'd0, htrans}, 32'd0);
        chk("t6_rst_haddr", haddr, 32'd0);
        chk("t6_rst_hsize", {29'd0, hsize}, 32'd2);
        chk("t6_rst_hwrite", {31'd0, hwrite}, 32'd0);
        chk("t6_rst_hwdata", hwdata, 32'd0);
        chk("t6_rst_err", {31'd0, err_flag}, 32'd0);
        drop(); hready = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_post_rst_ack", {31'd0, ack}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
